// File: rtl/comparador_serial_der_izq.sv
// comparador_serial_der_izq
// Serial magnitude comparator: walks two WIDTH-bit operands from the least
// significant DIGIT-bit slice upward, one slice per clock. The running
// relation lives in a 2-bit register. An unequal slice always overwrites it,
// so the most significant unequal slice decides the final result.
// Handshake: start (taken only in IDLE) -> busy during RUN -> one-cycle done.
// Optional build macro: COMPARADOR_SIGNED_EN (two's complement operands).
// WIDTH must be a positive multiple of DIGIT.
module comparador_serial_der_izq #(
    parameter int WIDTH = 12,
    parameter int DIGIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        P_EQ = 2'b00,
        P_GT = 2'b01,
        P_LT = 2'b10
    } rel_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt_q;
    rel_t             p_q;
    rel_t             p_d;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;
    logic [DIGIT-1:0] slice_a;
    logic [DIGIT-1:0] slice_b;

    // Compare the current low slice and derive the next partial relation
    always_comb begin
        slice_a = a_q[DIGIT-1:0];
        slice_b = b_q[DIGIT-1:0];
`ifdef COMPARADOR_SIGNED_EN
        // Top slice: flipping the sign bit turns two's complement into offset
        // binary, so an unsigned compare of that slice orders signed values.
        if (cnt_q == LAST) begin
            slice_a[DIGIT-1] = ~slice_a[DIGIT-1];
            slice_b[DIGIT-1] = ~slice_b[DIGIT-1];
        end
`endif
        p_d = p_q;
        if (slice_a > slice_b) begin
            p_d = P_GT;
        end else if (slice_a < slice_b) begin
            p_d = P_LT;
        end
    end

    // Control FSM with operand shifters and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            p_q     <= P_EQ;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        cnt_q   <= '0;
                        p_q     <= P_EQ;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    p_q <= p_d;
                    a_q <= a_q >> DIGIT;
                    b_q <= b_q >> DIGIT;
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        gt_q    <= (p_d == P_GT);
                        eq_q    <= (p_d == P_EQ);
                        lt_q    <= (p_d == P_LT);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// tb_comparador_serial_der_izq
// Two instances (12/3 defaults and 8/1) checked every cycle against a
// transaction-level model: on acceptance the final relation is computed with
// plain integer comparison and released STEPS cycles later.
module tb_comparador_serial_der_izq;

`ifdef COMPARADOR_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] a12;
    logic [11:0] b12;
    logic        busy, done, gt, eq, lt;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8, done8, gt8, eq8, lt8;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    comparador_serial_der_izq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a12), .B(b12),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    comparador_serial_der_izq #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Relation {gt,eq,lt} of two w-bit values, by integer comparison
    function automatic logic [2:0] rel(input logic [63:0] a, input logic [63:0] b, input int w);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (SIGNED_MODE) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        if (sa > sb) return 3'b100;
        if (sa == sb) return 3'b010;
        return 3'b001;
    endfunction

    // Transaction model, 12-bit instance
    logic       m_busy, m_done;
    logic [2:0] m_res, m_pend;
    int         m_rem;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_res <= 3'b010; m_pend <= 3'b010; m_rem <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_rem == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_res <= m_pend;
                end else m_rem <= m_rem - 1;
            end else if (start) begin
                m_busy <= 1'b1; m_rem <= 4; m_pend <= rel(64'(a12), 64'(b12), 12);
            end
        end
    end

    // Transaction model, 8-bit instance
    logic       n_busy, n_done;
    logic [2:0] n_res, n_pend;
    int         n_rem;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_busy <= 1'b0; n_done <= 1'b0; n_res <= 3'b010; n_pend <= 3'b010; n_rem <= 0;
        end else begin
            n_done <= 1'b0;
            if (n_busy) begin
                if (n_rem == 1) begin
                    n_busy <= 1'b0; n_done <= 1'b1; n_res <= n_pend;
                end else n_rem <= n_rem - 1;
            end else if (start8) begin
                n_busy <= 1'b1; n_rem <= 8; n_pend <= rel(64'(a8), 64'(b8), 8);
            end
        end
    end

    // Per-cycle comparison against both models
    always @(negedge clk) begin
        check("out12", 64'({busy, done, gt, eq, lt}), 64'({m_busy, m_done, m_res}));
        check("out8", 64'({busy8, done8, gt8, eq8, lt8}), 64'({n_busy, n_done, n_res}));
    end

    task automatic op12(input logic [11:0] a, input logic [11:0] b, input logic [2:0] exp,
                        input bit pin, input bit noise);
        int n;
        n = 0;
        while (busy && n < 20) begin @(posedge clk); #1; n++; end
        a12 = a; b12 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                a12 = 12'($urandom); b12 = 12'($urandom);
            end
            @(posedge clk); #1; n++;
        end
        start = 1'b0;
        if (n >= 20) check("timeout12", 64'(done), 64'(1));
        if (pin) begin
            check("latency12", 64'(n), 64'(4));
            check("result12", 64'({gt, eq, lt}), 64'(exp));
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] exp, input bit pin);
        int n;
        n = 0;
        while (busy8 && n < 30) begin @(posedge clk); #1; n++; end
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 30) begin @(posedge clk); #1; n++; end
        if (n >= 30) check("timeout8", 64'(done8), 64'(1));
        if (pin) begin
            check("latency8", 64'(n), 64'(8));
            check("result8", 64'({gt8, eq8, lt8}), 64'(exp));
        end
    endtask

    initial begin
        int n;
        logic [11:0] ra, rb;
        rst_n = 1'b1; start = 1'b0; a12 = '0; b12 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check("reset_async", 64'({busy, done, gt, eq, lt}), 64'(5'b00010));
        check("reset_async8", 64'({busy8, done8, gt8, eq8, lt8}), 64'(5'b00010));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        op12(12'h5A3, 12'h5A3, 3'b010, 1'b1, 1'b0);
        op12(12'h800, 12'h7FF, SIGNED_MODE ? 3'b001 : 3'b100, 1'b1, 1'b0);

        // start held high: second op accepted on the edge after done
        a12 = 12'h001; b12 = 12'h000; start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        check("held_lat1", 64'(n), 64'(4));
        check("held_res1", 64'({busy, gt, eq, lt}), 64'(4'b0100));
        @(posedge clk); #1;
        check("held_accept", 64'(busy), 64'(1));
        a12 = 12'h000; b12 = 12'h005;
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        start = 1'b0;
        check("held_lat2", 64'(n), 64'(4));
        check("held_res2", 64'({gt, eq, lt}), 64'(3'b100));
        @(posedge clk); #1;

        // Reset in the middle of a run (cnt==2)
        a12 = 12'hF00; b12 = 12'h0FF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("reset_mid", 64'({busy, done, gt, eq, lt}), 64'(5'b00010));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_nodone", 64'(done), 64'(0));
        op12(12'd3, 12'd9, 3'b001, 1'b1, 1'b0);

        // Randomized traffic with stray start pulses during RUN
        for (int i = 0; i < 150; i++) begin
            ra = 12'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 12'($urandom);
            op12(ra, rb, rel(64'(ra), 64'(rb), 12), 1'b1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // 8-bit, one bit per clock
        op8(8'h80, 8'h7F, SIGNED_MODE ? 3'b001 : 3'b100, 1'b1);
        for (int i = 0; i < 60; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = ($urandom_range(0, 3) == 0) ? x : 8'($urandom);
            op8(x, y, rel(64'(x), 64'(y), 8), 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/comparador_serial_der_izq.md
# comparador_serial_der_izq

Sequential, parametrised successor to the combinational 3-bit comparator cell chain. It compares two WIDTH-bit operands right-to-left (least significant slice first), one DIGIT-bit slice per clock, carrying the partial relation P in a register instead of through a wired chain of cells. It sits beside the structural comparators as the area-reduced option for wide operands and uses a start/done handshake.

## Interface
- WIDTH, default 12: operand width in bits; must be a positive multiple of DIGIT.
- DIGIT, default 3: slice width processed per clock; STEPS = WIDTH/DIGIT, with STEPS ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; sampled on the edge that accepts start.
- B  input  WIDTH  operand B; sampled on the edge that accepts start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.

## Operation
- FSM states: IDLE, RUN.
  - IDLE, start=1: latch A and B into shift registers, set cnt=0 and P=EQ, go to RUN.
  - RUN: each edge compares the lowest DIGIT bits of the registers, then shifts both right by DIGIT and increments cnt.
  - RUN, cnt==STEPS-1: perform that compare, write the result, pulse done, return to IDLE.
- P encoding is 2 bits: EQ=00, GT=01, LT=10. Code 11 is never produced.
- Slice rule (right-to-left semantics):
  - slice_a > slice_b: P←GT.
  - slice_a < slice_b: P←LT.
  - slice_a == slice_b: P unchanged.
  - A more significant unequal slice therefore overrides any earlier partial result.
- Comparisons are unsigned unless the signed option is compiled in (see Configuration).
- Result outputs: {gt,eq,lt} are registered, exactly one-hot after the first completion, and held unchanged until the next done.
- start while busy: ignored; the operation in progress is unaffected and no queueing occurs.
- A and B changing during RUN: no effect, because the operands are latched.
- start high on the same edge as done: not accepted, since the FSM is still in RUN on that edge. start is accepted on the next edge if still high.
- Reset (any time, including mid-RUN): asynchronously forces the following, and the operation is lost:
  - FSM to IDLE.
  - busy=0, done=0.
  - gt=0, eq=1, lt=0.
  - cnt=0, P=EQ.
  - Operand registers to 0.

## Timing
- Edge k accepts start. busy=1 from after edge k.
- Edges k+1 … k+STEPS process the slices.
- done=1 and the new result are visible after edge k+STEPS, for exactly one cycle. busy=0 in that same cycle.
- Latency from start acceptance to done: STEPS cycles, which is 4 for the defaults.
- Back-to-back throughput: a new start is accepted at edge k+STEPS+1 at the earliest, giving one result per STEPS+1 cycles.
- STEPS=1 degenerate case: done follows the start edge by one cycle.
- No combinational path from inputs to outputs.

## Configuration
- COMPARADOR_SIGNED_EN defined: operands are two's complement. On the final slice (the most significant, cnt==STEPS-1), the slice MSBs are inverted before the compare, so the sign bit decides first. Lower slices still compare unsigned.
- COMPARADOR_SIGNED_EN undefined: all slices compare unsigned, and the extra logic is absent.

## Test plan
- Reset then idle: rst_n low mid-cycle -> immediately busy=0, done=0, {gt,eq,lt}=010 with no clock.
- Defaults, A=12'h5A3, B=12'h5A3, start -> done exactly 4 cycles after acceptance, {gt,eq,lt}=010.
- A=12'h800, B=12'h7FF (unsigned) -> low slices give LT, top slice overrides -> {gt,eq,lt}=100. With COMPARADOR_SIGNED_EN -> 001.
- A=12'h001, B=12'h000, then start held high continuously -> first done gives 100. Second operation accepted on the edge after done; start pulses during RUN are ignored.
- rst_n asserted at cnt==2 of a run with A>B -> outputs return to reset values, done never pulses, and a fresh start of A=3, B=9 yields 001 after 4 cycles.
- WIDTH=8, DIGIT=1, A=8'h80, B=8'h7F -> done after 8 cycles, {gt,eq,lt}=100.
